uart_ctrl: RTL and testbench

Serial-port access sequencer on the memory path of the 16-bit CPU. It sits between the MEM-stage request (`en`/`op`/`addr`/`data_i`) and the board's CPLD UART pins (`rdn`, `wrn`, `tbre`, `tsre`, `data_ready`). It decodes the two serial addresses, runs the multi-cycle CPLD strobe/handshake and stalls the pipeline through `com_pause` until the transfer finishes. The RAM controller handles every other address and forwards serial accesses here.

---
 rtl/uart_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPLD UART access sequencer on the CPU memory path (data at BF00, status at BF01).
// Define UART_RX_FIFO_EN to add a 4-entry background receive FIFO; the default build uses blocking reads.
module uart_ctrl #(
    parameter int WR_PULSE = 2,
    parameter int RD_PULSE = 2
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        en,
    input  logic        op,
    input  logic [17:0] addr,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        com_pause,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe,
    output logic        rdn,
    output logic        wrn,
    input  logic        tbre,
    input  logic        tsre,
    input  logic        data_ready
);
    localparam logic        RAM_OP_RD = 1'b0;
    localparam logic        RAM_OP_WR = 1'b1;
    localparam logic [17:0] ADDR_DATA = 18'h0BF00;
    localparam logic [17:0] ADDR_STAT = 18'h0BF01;
    localparam int          CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PULSE, S_WR_HOLD, S_WR_TBRE, S_WR_TSRE, S_RD_WAIT, S_RD_PULSE, S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       rx_reg;
    logic             tbre_p0, tsre_p0, dr_p0;
    logic             tbre_s, tsre_s, dr_s;
    logic             dreq, sreq, dwr, drd, srd;
    logic             tx_ready, rx_avail;
    logic [15:0]      status;
    logic             unused_ok;

    assign dreq      = en && (addr == ADDR_DATA);
    assign sreq      = en && (addr == ADDR_STAT);
    assign dwr       = dreq && (op == RAM_OP_WR);
    assign drd       = dreq && (op == RAM_OP_RD);
    assign srd       = sreq && (op == RAM_OP_RD);
    assign tx_ready  = tbre_s && tsre_s && (state == S_IDLE);
    assign status    = {14'b0, rx_avail, tx_ready};
    assign unused_ok = &{1'b0, data_i[15:8]};

    // CPLD flags are asynchronous: two-flop synchronizers
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            tbre_p0 <= 1'b0;
            tsre_p0 <= 1'b0;
            dr_p0   <= 1'b0;
            tbre_s  <= 1'b0;
            tsre_s  <= 1'b0;
            dr_s    <= 1'b0;
        end else begin
            tbre_p0 <= tbre;
            tsre_p0 <= tsre;
            dr_p0   <= data_ready;
            tbre_s  <= tbre_p0;
            tsre_s  <= tsre_p0;
            dr_s    <= dr_p0;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       bg, push, pop;

    // Every RD_PULSE is a background fetch in this build, so its last cycle is the push.
    assign push      = (state == S_RD_PULSE) && (cnt == '0);
    assign pop       = drd && (count != 3'd0);
    assign rx_avail  = (count != 3'd0);
    assign com_pause = rst && ((dwr && !((state == S_DONE) && !bg)) || (drd && (count == 3'd0)));
    assign data_o    = !rst ? 16'h0000 :
                       srd ? status :
                       (count != 3'd0) ? {8'h00, fifo_mem[rd_ptr]} : {8'h00, rx_reg};
`else
    assign rx_avail  = dr_s;
    assign com_pause = rst && dreq && (state != S_DONE);
    assign data_o    = !rst ? 16'h0000 : (srd ? status : {8'h00, rx_reg});
`endif

    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rdn         <= 1'b1;
            wrn         <= 1'b1;
            bus_data_oe <= 1'b0;
            bus_data_o  <= '0;
            rx_reg      <= '0;
`ifdef UART_RX_FIFO_EN
            bg     <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
`endif
        end else begin
`ifdef UART_RX_FIFO_EN
            if (push) begin
                fifo_mem[wr_ptr] <= bus_data_i;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
`endif
            case (state)
                S_IDLE: begin
                    if (dwr) begin
                        state       <= S_WR_PULSE;
                        wrn         <= 1'b0;
                        bus_data_oe <= 1'b1;
                        bus_data_o  <= data_i[7:0];
                        cnt         <= CNT_W'(WR_PULSE - 1);
                    end
`ifdef UART_RX_FIFO_EN
                    else if (dr_s && !count[2]) begin
                        state <= S_RD_PULSE;
                        rdn   <= 1'b0;
                        cnt   <= CNT_W'(RD_PULSE - 1);
                        bg    <= 1'b1;
                    end
`else
                    else if (drd) begin
                        state <= S_RD_WAIT;
                    end
`endif
                end
                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        state <= S_WR_HOLD;
                        wrn   <= 1'b1;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                // Two fixed cycles: data held one cycle past wrn, and stale synced flags are skipped
                S_WR_HOLD: begin
                    if (cnt != '0) begin
                        cnt         <= cnt - CNT_W'(1);
                        bus_data_oe <= 1'b0;
                    end else begin
                        state <= S_WR_TBRE;
                    end
                end
                S_WR_TBRE: if (tbre_s) state <= S_WR_TSRE;
                S_WR_TSRE: if (tsre_s) state <= S_DONE;
                S_RD_WAIT: begin
                    if (dr_s) begin
                        state <= S_RD_PULSE;
                        rdn   <= 1'b0;
                        cnt   <= CNT_W'(RD_PULSE - 1);
                    end
                end
                S_RD_PULSE: begin
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        rdn    <= 1'b1;
                        rx_reg <= bus_data_i;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
`ifdef UART_RX_FIFO_EN
                    bg <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: randomized self-checking bench for uart_ctrl.
// Expected latencies come from a transaction-level timing model; flags reach the FSM two edges after changing.
module tb_uart_ctrl;
    localparam int          WRP    = 2;
    localparam int          RDP    = 2;
    localparam logic [17:0] A_DATA = 18'h0BF00;
    localparam logic [17:0] A_STAT = 18'h0BF01;
    localparam logic        OP_RD  = 1'b0;
    localparam logic        OP_WR  = 1'b1;
    localparam int          BUDGET = 80;

    logic        clk_50MHz = 1'b0;
    logic        rst, en, op;
    logic [17:0] addr;
    logic [15:0] data_i, data_o;
    logic        com_pause;
    logic [7:0]  bus_data_i, bus_data_o;
    logic        bus_data_oe, rdn, wrn;
    logic        tbre, tsre, data_ready;

    int total = 0;
    int bad   = 0;

    uart_ctrl #(.WR_PULSE(WRP), .RD_PULSE(RDP)) dut (
        .clk_50MHz(clk_50MHz), .rst(rst), .en(en), .op(op), .addr(addr),
        .data_i(data_i), .data_o(data_o), .com_pause(com_pause),
        .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
        .rdn(rdn), .wrn(wrn), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A flag with release cycle r reads 1 in every cycle c >= r of the transaction (r < 0: already high).
    task automatic run_write(input logic [15:0] d, input int r_tb, input int r_ts);
        int t_tb, t_ts, exp_done, done, wlo, wfirst, oe_n, rlo;
        logic [7:0] b1;
        tbre = (r_tb < 0); tsre = (r_ts < 0); data_ready = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk_50MHz);
        #1;
        en = 1'b1; op = OP_WR; addr = A_DATA; data_i = d;
        t_tb     = imax(1 + WRP + 2, r_tb + 2);
        t_ts     = imax(t_tb + 1, r_ts + 2);
        exp_done = t_ts + 1;
        done = -1; wlo = 0; wfirst = -1; oe_n = 0; rlo = 0; b1 = '0;
        for (int c = 0; c < BUDGET; c++) begin
            tbre = (c >= r_tb); tsre = (c >= r_ts);
            @(negedge clk_50MHz);
            if (!wrn) begin
                wlo++;
                if (wfirst < 0) wfirst = c;
                if (c == 1) b1 = bus_data_o;
            end
            if (bus_data_oe) oe_n++;
            if (!rdn) rlo++;
            if (!com_pause) begin
                done = c;
                break;
            end
            @(posedge clk_50MHz); #1;
        end
        check_eq("wr_pause_cycles", done, exp_done);
        check_eq("wr_wrn_low_cycles", wlo, WRP);
        check_eq("wr_wrn_first", wfirst, 1);
        check_eq("wr_bus_byte", b1, d[7:0]);
        check_eq("wr_oe_cycles", oe_n, WRP + 1);
        check_eq("wr_rdn_quiet", rlo, 0);
        @(posedge clk_50MHz); #1;
        en = 1'b0;
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic run_read(input logic [7:0] b, input int r_dr);
        int start, exp_done, done, rlo, rfirst, wlo;
        logic [15:0] dout;
        data_ready = (r_dr < 0); tbre = 1'b1; tsre = 1'b1; en = 1'b0; bus_data_i = b;
        repeat (3) @(posedge clk_50MHz);
        #1;
        en = 1'b1; op = OP_RD; addr = A_DATA; data_i = 16'($urandom);
        start    = imax(1, r_dr + 2);
        exp_done = start + RDP + 1;
        done = -1; rlo = 0; rfirst = -1; wlo = 0; dout = '0;
        for (int c = 0; c < BUDGET; c++) begin
            data_ready = (c >= r_dr);
            @(negedge clk_50MHz);
            if (!rdn) begin
                rlo++;
                if (rfirst < 0) rfirst = c;
            end
            if (!wrn) wlo++;
            if (!com_pause) begin
                done = c;
                dout = data_o;
                break;
            end
            @(posedge clk_50MHz); #1;
        end
        check_eq("rd_pause_cycles", done, exp_done);
        check_eq("rd_rdn_low_cycles", rlo, RDP);
        check_eq("rd_rdn_first", rfirst, start + 1);
        check_eq("rd_data", dout, {8'h00, b});
        check_eq("rd_wrn_quiet", wlo, 0);
        @(posedge clk_50MHz); #1;
        en = 1'b0; data_ready = 1'b0;
    endtask
`endif

`ifdef UART_RX_FIFO_EN
    logic [7:0] cq[$];
    logic       rdn_q;
    int         falls;

    // CPLD model: data_ready clears when rdn falls, next byte offered once rdn rises.
    task automatic cpld_step();
        if (!rdn && rdn_q) begin
            data_ready = 1'b0;
            falls++;
        end
        if (rdn && !rdn_q && cq.size() > 0) begin
            void'(cq.pop_front());
            data_ready = (cq.size() > 0);
        end
        rdn_q      = rdn;
        bus_data_i = (cq.size() > 0) ? cq[0] : 8'h00;
    endtask

    task automatic run_fifo();
        cq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rdn_q = 1'b1; falls = 0; en = 1'b0; tbre = 1'b1; tsre = 1'b1;
        bus_data_i = 8'h01; data_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_50MHz);
            cpld_step();
        end
        check_eq("fifo_fetched", falls, 4);
        check_eq("fifo_rdn_idle", rdn, 1);
        check_eq("fifo_left_in_cpld", cq.size(), 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_50MHz); #1;
            en = 1'b1; op = OP_RD; addr = A_DATA;
            @(negedge clk_50MHz);
            check_eq("fifo_rd_pause", com_pause, 0);
            check_eq("fifo_rd_data", data_o, k);
            cpld_step();
        end
        @(posedge clk_50MHz); #1;
        en = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_50MHz);
            cpld_step();
        end
        check_eq("fifo_fifth_fetched", falls, 5);
        @(posedge clk_50MHz); #1;
        en = 1'b1; op = OP_RD; addr = A_DATA;
        @(negedge clk_50MHz);
        check_eq("fifo_rd5_pause", com_pause, 0);
        check_eq("fifo_rd5_data", data_o, 5);
        @(posedge clk_50MHz); #1;
        en = 1'b0; data_ready = 1'b0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int kind, ra, rb;
        rst = 1'b0; en = 1'b1; op = OP_WR; addr = A_DATA; data_i = 16'h1241;
        bus_data_i = 8'h00; tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0;

        // reset held with a live request
        repeat (3) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        check_eq("rst_rdn", rdn, 1);
        check_eq("rst_wrn", wrn, 1);
        check_eq("rst_oe", bus_data_oe, 0);
        check_eq("rst_data_o", data_o, 16'h0000);
        check_eq("rst_pause", com_pause, 0);
        check_eq("rst_bus_o", bus_data_o, 8'h00);
        @(posedge clk_50MHz); #1;
        en = 1'b0; rst = 1'b1;

        run_write(16'h1241, -5, -5);
        run_write(16'h1241, 8, -5);
`ifndef UART_RX_FIFO_EN
        run_read(8'h5A, -5);
`endif

        // status reads never pause; rx_avail follows data_ready through the synchronizer
        tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk_50MHz);
        #1;
        en = 1'b1; op = OP_RD; addr = A_STAT;
        for (int c = 0; c < 5; c++) begin
            logic rx_exp;
            rx_exp = 1'b0;
`ifndef UART_RX_FIFO_EN
            data_ready = (c >= 1);
            rx_exp     = (c >= 3);
`endif
            @(negedge clk_50MHz);
            check_eq("st_data", data_o, {14'b0, rx_exp, 1'b1});
            check_eq("st_pause", com_pause, 0);
            @(posedge clk_50MHz); #1;
        end
        op = OP_WR; data_i = 16'h00AA;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_50MHz);
            check_eq("st_wr_pause", com_pause, 0);
            check_eq("st_wr_wrn", wrn, 1);
            @(posedge clk_50MHz); #1;
        end
        en = 1'b0; data_ready = 1'b0;

        // reset during the first WR_PULSE cycle
        repeat (3) @(posedge clk_50MHz);
        #1;
        en = 1'b1; op = OP_WR; addr = A_DATA; data_i = 16'h0033;
        @(negedge clk_50MHz);
        @(posedge clk_50MHz); #1;
        rst = 1'b0;
        @(negedge clk_50MHz);
        check_eq("mid_wrn_before", wrn, 0);
        @(posedge clk_50MHz); #1;
        rst = 1'b1; en = 1'b0;
        @(negedge clk_50MHz);
        check_eq("mid_wrn_after", wrn, 1);
        check_eq("mid_oe_after", bus_data_oe, 0);
        check_eq("mid_pause_after", com_pause, 0);
        repeat (3) @(posedge clk_50MHz);
        #1;
        en = 1'b1; op = OP_RD; addr = A_STAT;
        @(negedge clk_50MHz);
        check_eq("mid_idle_status", data_o, 16'h0001);
        @(posedge clk_50MHz); #1;
        en = 1'b0;

        for (int i = 0; i < 12; i++) begin
`ifdef UART_RX_FIFO_EN
            kind = 0;
`else
            kind = int'($urandom_range(0, 1));
`endif
            ra = ($urandom_range(0, 2) == 0) ? -5 : int'($urandom_range(0, 8));
            rb = ($urandom_range(0, 2) == 0) ? -5 : int'($urandom_range(0, 8));
            if (kind == 0) run_write(16'($urandom), ra, rb);
`ifndef UART_RX_FIFO_EN
            else run_read(8'($urandom), ra);
`endif
        end

`ifdef UART_RX_FIFO_EN
        run_fifo();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
